// File: rtl/rvvi_retire_serializer_pkg.sv
// Shared constants, order-check states and GPR writeback decode for the RVVI retire serializer.
package rvvi_trace_pkg;

  localparam int RVVI_TRACE_VERSION_MAJOR = 1;
  localparam int RVVI_TRACE_VERSION_MINOR = 4;
  localparam int DROP_CNT_W = 16;

  typedef enum logic {
    UNSEEDED = 1'b0,
    SEEDED   = 1'b1
  } order_state_e;

  // Returns {we, rd}; x0 never counts as a write and the lowest other set bit wins.
  function automatic logic [5:0] gpr_decode(input logic [31:0] x_wb);
    logic [5:0] r;
    r = '0;
    for (int i = 31; i >= 1; i--) begin
      if (x_wb[i]) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/rvvi_retire_serializer_if.sv
// Retire-group input and single-record output stream of the RVVI retire serializer.
interface rvvi_retire_serializer_if #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int RETIRE = 2
);
  logic [RETIRE-1:0]      in_valid;
  logic [RETIRE*64-1:0]   in_order;
  logic [RETIRE*ILEN-1:0] in_insn;
  logic [RETIRE*XLEN-1:0] in_pc_rdata;
  logic [RETIRE*XLEN-1:0] in_pc_wdata;
  logic [RETIRE-1:0]      in_trap;
  logic [RETIRE-1:0]      in_halt;
  logic [RETIRE*2-1:0]    in_mode;
  logic [RETIRE*32-1:0]   in_x_wb;
  logic [RETIRE*XLEN-1:0] in_x_wdata;
  logic                   in_ready;

  logic                   out_valid;
  logic                   out_ready;
  logic [63:0]            out_order;
  logic [ILEN-1:0]        out_insn;
  logic [XLEN-1:0]        out_pc_rdata;
  logic [XLEN-1:0]        out_pc_wdata;
  logic                   out_trap;
  logic                   out_halt;
  logic [1:0]             out_mode;
  logic [4:0]             out_rd;
  logic                   out_rd_we;
  logic [XLEN-1:0]        out_rd_wdata;

  modport master (
    output in_valid, in_order, in_insn, in_pc_rdata, in_pc_wdata, in_trap, in_halt,
           in_mode, in_x_wb, in_x_wdata, out_ready,
    input  in_ready, out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata,
           out_trap, out_halt, out_mode, out_rd, out_rd_we, out_rd_wdata
  );

  modport slave (
    input  in_valid, in_order, in_insn, in_pc_rdata, in_pc_wdata, in_trap, in_halt,
           in_mode, in_x_wb, in_x_wdata, out_ready,
    output in_ready, out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata,
           out_trap, out_halt, out_mode, out_rd, out_rd_we, out_rd_wdata
  );
endinterface

// File: rtl/rvvi_retire_fifo.sv
// Multi-write, single-read FIFO: valid write slots are packed lowest-index first into consecutive entries.
module rvvi_retire_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int NWR   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [NWR-1:0]         wr_valid,
  input  logic [NWR*WIDTH-1:0]   wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_addr [NWR];
  logic [CW-1:0]    push_cnt;
  logic             pop;

  // Each valid slot lands at the write pointer plus the number of valid slots below it.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NWR; i++) begin
      wr_addr[i] = wr_ptr + push_cnt[AW-1:0];
      push_cnt   = push_cnt + CW'(wr_valid[i]);
    end
    if (!wr_en) push_cnt = '0;
  end

  assign pop     = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NWR; i++) begin
      if (wr_en && wr_valid[i]) mem[wr_addr[i]] <= wr_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_cnt[AW-1:0];
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + push_cnt - CW'(pop);
    end
  end

endmodule

// File: rtl/rvvi_retire_serializer.sv
// Serializes up to RETIRE retired-instruction records per cycle into one record per cycle, with order and overflow checks.
// Optional statistics ports are enabled by defining RVVI_RETIRE_SERIALIZER_STATS_EN.
module rvvi_retire_serializer
  import rvvi_trace_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int RETIRE = 2,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rvvi_retire_serializer_if.slave bus,
  output logic                   err_order,
  output logic [63:0]            err_order_exp,
  output logic [63:0]            err_order_got,
  output logic                   err_overflow,
  output logic [DROP_CNT_W-1:0]  drop_count
`ifdef RVVI_RETIRE_SERIALIZER_STATS_EN
  ,
  output logic [63:0]            stat_retired,
  output logic [31:0]            stat_traps,
  output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [63:0]     order;
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic            trap;
    logic            halt;
    logic [1:0]      mode;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] rd_wdata;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  logic [RETIRE*REC_W-1:0] wr_data;
  logic [REC_W-1:0]        rd_data;
  logic [CW-1:0]           count;
  logic                    in_ready;
  logic                    out_valid;
  logic                    pop;
  logic                    overflow_hit;
  logic [2:0]              drop_n;
  logic [DROP_CNT_W:0]     drop_sum;
  rec_t                    head;
  rec_t                    slot_rec;
  logic [5:0]              slot_dec;
  order_state_e            state;
  order_state_e            state_next;
  logic [63:0]             expected;
  logic [63:0]             expected_next;
  logic                    err_hit;

  // Records carry the decoded GPR write so the head needs no further decode.
  always_comb begin
    wr_data  = '0;
    slot_rec = '0;
    slot_dec = '0;
    for (int i = 0; i < RETIRE; i++) begin
      slot_dec          = gpr_decode(bus.in_x_wb[i*32 +: 32]);
      slot_rec.order    = bus.in_order[i*64 +: 64];
      slot_rec.insn     = bus.in_insn[i*ILEN +: ILEN];
      slot_rec.pc_rdata = bus.in_pc_rdata[i*XLEN +: XLEN];
      slot_rec.pc_wdata = bus.in_pc_wdata[i*XLEN +: XLEN];
      slot_rec.trap     = bus.in_trap[i];
      slot_rec.halt     = bus.in_halt[i];
      slot_rec.mode     = bus.in_mode[i*2 +: 2];
      slot_rec.rd       = slot_dec[4:0];
      slot_rec.rd_we    = slot_dec[5];
      slot_rec.rd_wdata = bus.in_x_wdata[i*XLEN +: XLEN];
      wr_data[i*REC_W +: REC_W] = slot_rec;
    end
  end

  rvvi_retire_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH),
    .NWR   (RETIRE)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (in_ready),
    .wr_valid (bus.in_valid),
    .wr_data  (wr_data),
    .rd_en    (bus.out_ready),
    .rd_data  (rd_data),
    .count    (count)
  );

  // Space is judged on the registered count so a same-cycle pop never admits a group.
  assign in_ready     = (CW'(DEPTH) - count) >= CW'(RETIRE);
  assign out_valid    = count != '0;
  assign pop          = out_valid && bus.out_ready;
  assign head         = out_valid ? rec_t'(rd_data) : '0;
  assign overflow_hit = !in_ready && (|bus.in_valid);

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < RETIRE; i++) drop_n = drop_n + 3'(bus.in_valid[i]);
  end

  assign drop_sum = {1'b0, drop_count} + (DROP_CNT_W+1)'(drop_n);

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_order    = head.order;
  assign bus.out_insn     = head.insn;
  assign bus.out_pc_rdata = head.pc_rdata;
  assign bus.out_pc_wdata = head.pc_wdata;
  assign bus.out_trap     = head.trap;
  assign bus.out_halt     = head.halt;
  assign bus.out_mode     = head.mode;
  assign bus.out_rd       = head.rd;
  assign bus.out_rd_we    = head.rd_we;
  assign bus.out_rd_wdata = head.rd_wdata;

  // After any pop the next expected order is this one plus one, so a gap resynchronises checking.
  always_comb begin
    state_next    = state;
    expected_next = expected;
    err_hit       = 1'b0;
    if (pop) begin
      expected_next = head.order + 64'd1;
      case (state)
        UNSEEDED: state_next = SEEDED;
        SEEDED:   err_hit    = head.order != expected;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= UNSEEDED;
      expected      <= '0;
      err_order     <= 1'b0;
      err_order_exp <= '0;
      err_order_got <= '0;
      err_overflow  <= 1'b0;
      drop_count    <= '0;
    end else begin
      state    <= state_next;
      expected <= expected_next;
      if (err_hit) begin
        err_order <= 1'b1;
        if (!err_order) begin
          err_order_exp <= expected;
          err_order_got <= head.order;
        end
      end
      if (overflow_hit) begin
        err_overflow <= 1'b1;
        drop_count   <= drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
      end
    end
  end

`ifdef RVVI_RETIRE_SERIALIZER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_retired <= '0;
      stat_traps   <= '0;
      stat_max_occ <= '0;
    end else begin
      if (pop) stat_retired <= stat_retired + 64'd1;
      if (pop && head.trap) stat_traps <= stat_traps + 32'd1;
      if (count > stat_max_occ) stat_max_occ <= count;
    end
  end
`endif

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
// Directed bench for rvvi_retire_serializer: inputs change and outputs are sampled on the falling clock edge.
module tb_rvvi_retire_serializer;
  import rvvi_trace_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        err_order;
  logic [63:0] err_order_exp;
  logic [63:0] err_order_got;
  logic        err_overflow;
  logic [15:0] drop_count;
  int          tests;
  int          fails;

  rvvi_retire_serializer_if #(.XLEN(32), .ILEN(32), .RETIRE(2)) bus ();

  rvvi_retire_serializer #(.XLEN(32), .ILEN(32), .RETIRE(2), .DEPTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .err_order     (err_order),
    .err_order_exp (err_order_exp),
    .err_order_got (err_order_got),
    .err_overflow  (err_overflow),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic idle();
    bus.in_valid    = '0;
    bus.in_order    = '0;
    bus.in_insn     = '0;
    bus.in_pc_rdata = '0;
    bus.in_pc_wdata = '0;
    bus.in_trap     = '0;
    bus.in_halt     = '0;
    bus.in_mode     = '0;
    bus.in_x_wb     = '0;
    bus.in_x_wdata  = '0;
  endtask

  // Record fields are derived from the order so every field has a predictable value.
  task automatic put(input int s, input logic [63:0] ord, input logic [31:0] xwb);
    bus.in_valid[s]             = 1'b1;
    bus.in_order[s*64 +: 64]    = ord;
    bus.in_insn[s*32 +: 32]     = 32'h1000_0000 | ord[31:0];
    bus.in_pc_rdata[s*32 +: 32] = {ord[29:0], 2'b00};
    bus.in_pc_wdata[s*32 +: 32] = {ord[29:0], 2'b00} + 32'd4;
    bus.in_trap[s]              = ord[0];
    bus.in_halt[s]              = 1'b0;
    bus.in_mode[s*2 +: 2]       = 2'b11;
    bus.in_x_wb[s*32 +: 32]     = xwb;
    bus.in_x_wdata[s*32 +: 32]  = 32'hD000_0000 | ord[31:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    tests++; if (bus.out_order !== 64'd0) begin fails++; $display("[TB] FAIL reset_out_order got=%0h exp=0", bus.out_order); end
    tests++; if ({err_order, err_overflow, drop_count} !== 18'd0) begin fails++; $display("[TB] FAIL reset_errors got=%b/%b/%0d exp=0/0/0", err_order, err_overflow, drop_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    put(0, 64'd0, 32'h0000_0020);
    put(1, 64'd1, 32'h0);
    @(negedge clk);
    idle();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid got=%b exp=1", bus.out_valid); end
    tests++; if (bus.out_order !== 64'd0) begin fails++; $display("[TB] FAIL basic_order0 got=%0h exp=0", bus.out_order); end
    tests++; if (bus.out_rd !== 5'd5 || bus.out_rd_we !== 1'b1) begin fails++; $display("[TB] FAIL basic_rd got=%0d/%b exp=5/1", bus.out_rd, bus.out_rd_we); end
    tests++; if (bus.out_rd_wdata !== 32'hD000_0000) begin fails++; $display("[TB] FAIL basic_wdata got=%0h exp=d0000000", bus.out_rd_wdata); end
    tests++; if (bus.out_insn !== 32'h1000_0000 || bus.out_pc_wdata !== 32'd4 || bus.out_mode !== 2'b11) begin fails++; $display("[TB] FAIL basic_fields got=%0h/%0h/%0d exp=10000000/4/3", bus.out_insn, bus.out_pc_wdata, bus.out_mode); end
    @(negedge clk);
    tests++; if (bus.out_order !== 64'd1 || bus.out_trap !== 1'b1 || bus.out_pc_rdata !== 32'd4) begin fails++; $display("[TB] FAIL basic_order1 got=%0h/%b/%0h exp=1/1/4", bus.out_order, bus.out_trap, bus.out_pc_rdata); end
    tests++; if (bus.out_rd_we !== 1'b0) begin fails++; $display("[TB] FAIL basic_nowrite got=%b exp=0", bus.out_rd_we); end
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0 || err_order !== 1'b0) begin fails++; $display("[TB] FAIL basic_drain got=%b/%b exp=0/0", bus.out_valid, err_order); end
  endtask

  task automatic test_sparse();
    put(0, 64'd2, 32'h0);
    put(1, 64'd3, 32'h0000_0001);
    @(negedge clk);
    idle();
    tests++; if (bus.out_order !== 64'd2) begin fails++; $display("[TB] FAIL sparse_order2 got=%0h exp=2", bus.out_order); end
    put(0, 64'd4, 32'h0000_0088);
    @(negedge clk);
    idle();
    tests++; if (bus.out_order !== 64'd3 || bus.out_rd_we !== 1'b0) begin fails++; $display("[TB] FAIL sparse_x0 got=%0h/%b exp=3/0", bus.out_order, bus.out_rd_we); end
    put(1, 64'd5, 32'h0);
    bus.in_order[63:0] = 64'd99;
    @(negedge clk);
    idle();
    tests++; if (bus.out_order !== 64'd4 || bus.out_rd !== 5'd3 || bus.out_rd_we !== 1'b1) begin fails++; $display("[TB] FAIL sparse_lowbit got=%0h/%0d/%b exp=4/3/1", bus.out_order, bus.out_rd, bus.out_rd_we); end
    @(negedge clk);
    tests++; if (bus.out_order !== 64'd5 || bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL sparse_order5 got=%0h/%b exp=5/1", bus.out_order, bus.out_valid); end
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0 || err_order !== 1'b0) begin fails++; $display("[TB] FAIL sparse_drain got=%b/%b exp=0/0", bus.out_valid, err_order); end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      put(0, 64'(6 + 2*g), 32'h0);
      put(1, 64'(7 + 2*g), 32'h0);
      @(negedge clk);
      idle();
    end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL ovf_ready_at6 got=%b exp=1", bus.in_ready); end
    put(0, 64'd12, 32'h0);
    @(negedge clk);
    idle();
    tests++; if (bus.in_ready !== 1'b0 || err_overflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_ready_at7 got=%b/%b exp=0/0", bus.in_ready, err_overflow); end
    put(0, 64'd50, 32'h0);
    put(1, 64'd51, 32'h0);
    @(negedge clk);
    idle();
    tests++; if (err_overflow !== 1'b1 || drop_count !== 16'd2) begin fails++; $display("[TB] FAIL ovf_flag got=%b/%0d exp=1/2", err_overflow, drop_count); end
    tests++; if (bus.out_valid !== 1'b1 || bus.out_order !== 64'd6) begin fails++; $display("[TB] FAIL ovf_head got=%b/%0h exp=1/6", bus.out_valid, bus.out_order); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tests++; if (bus.out_order !== 64'(6 + k)) begin fails++; $display("[TB] FAIL ovf_drain%0d got=%0h exp=%0h", k, bus.out_order, 6 + k); end
      @(negedge clk);
    end
    tests++; if (bus.out_valid !== 1'b0 || err_order !== 1'b0) begin fails++; $display("[TB] FAIL ovf_empty got=%b/%b exp=0/0", bus.out_valid, err_order); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      put(0, 64'(13 + 2*g), 32'h0);
      put(1, 64'(14 + 2*g), 32'h0);
      @(negedge clk);
      idle();
    end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready_at6 got=%b exp=1", bus.in_ready); end
    bus.out_ready = 1'b1;
    put(0, 64'd19, 32'h0);
    put(1, 64'd20, 32'h0);
    @(negedge clk);
    idle();
    tests++; if (bus.in_ready !== 1'b0 || bus.out_order !== 64'd14 || drop_count !== 16'd2) begin fails++; $display("[TB] FAIL b2b_push_pop got=%b/%0h/%0d exp=0/e/2", bus.in_ready, bus.out_order, drop_count); end
    put(0, 64'd21, 32'h0);
    put(1, 64'd22, 32'h0);
    @(negedge clk);
    idle();
    tests++; if (drop_count !== 16'd4 || bus.out_order !== 64'd15 || bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_pop_no_room got=%0d/%0h/%b exp=4/f/1", drop_count, bus.out_order, bus.in_ready); end
    for (int k = 0; k < 6; k++) begin
      tests++; if (bus.out_order !== 64'(15 + k)) begin fails++; $display("[TB] FAIL b2b_drain%0d got=%0h exp=%0h", k, bus.out_order, 15 + k); end
      @(negedge clk);
    end
    tests++; if (bus.out_valid !== 1'b0 || err_order !== 1'b0) begin fails++; $display("[TB] FAIL b2b_empty got=%b/%b exp=0/0", bus.out_valid, err_order); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    put(0, 64'd21, 32'h0);
    put(1, 64'd22, 32'h0);
    @(negedge clk);
    put(0, 64'd23, 32'h0);
    put(1, 64'd24, 32'h0);
    @(negedge clk);
    idle();
    tests++; if (bus.out_valid !== 1'b1 || err_overflow !== 1'b1) begin fails++; $display("[TB] FAIL arst_pre got=%b/%b exp=1/1", bus.out_valid, err_overflow); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_order !== 64'd0 || bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL arst_fifo got=%b/%0h/%b exp=0/0/1", bus.out_valid, bus.out_order, bus.in_ready); end
    tests++; if (err_overflow !== 1'b0 || drop_count !== 16'd0 || err_order !== 1'b0) begin fails++; $display("[TB] FAIL arst_errors got=%b/%0d/%b exp=0/0/0", err_overflow, drop_count, err_order); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_order_gap();
    bus.out_ready = 1'b1;
    put(0, 64'd10, 32'h0);
    put(1, 64'd11, 32'h0);
    @(negedge clk);
    idle();
    put(0, 64'd13, 32'h0);
    put(1, 64'd14, 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    tests++; if (err_order !== 1'b0 || bus.out_order !== 64'd13) begin fails++; $display("[TB] FAIL gap_reseed got=%b/%0h exp=0/d", err_order, bus.out_order); end
    @(negedge clk);
    tests++; if (err_order !== 1'b1 || err_order_exp !== 64'd12 || err_order_got !== 64'd13) begin fails++; $display("[TB] FAIL gap_capture got=%b/%0d/%0d exp=1/12/13", err_order, err_order_exp, err_order_got); end
    @(negedge clk);
    put(0, 64'd30, 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    tests++; if (err_order !== 1'b1 || err_order_exp !== 64'd12 || err_order_got !== 64'd13 || bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL gap_first_only got=%b/%0d/%0d/%b exp=1/12/13/0", err_order, err_order_exp, err_order_got, bus.out_valid); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    put(0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0);
    put(1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0);
    @(negedge clk);
    idle();
    put(0, 64'd0, 32'h0);
    @(negedge clk);
    idle();
    tests++; if (bus.out_order !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("[TB] FAIL wrap_max got=%0h exp=ffffffffffffffff", bus.out_order); end
    @(negedge clk);
    tests++; if (bus.out_order !== 64'd0 || err_order !== 1'b0) begin fails++; $display("[TB] FAIL wrap_zero got=%0h/%b exp=0/0", bus.out_order, err_order); end
    @(negedge clk);
    tests++; if (err_order !== 1'b0 || bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL wrap_done got=%b/%b exp=0/0", err_order, bus.out_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_sparse();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_order_gap();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rvvi_retire_serializer.md
Name: rvvi_retire_serializer

Overview:
- Sits directly downstream of the rvviTrace interface, for one hart.
- Accepts up to RETIRE retired-instruction records per clock and buffers them in a multi-write, single-read FIFO.
- Emits one record per clock on a valid/ready stream for the trace writer and comparator.
- Checks the order field for gaps or reuse, and flags overflow.

Parameters:
- XLEN, 32, GPR/PC width in bits
- ILEN, 32, instruction width in bits
- RETIRE, 2, slots per cycle; 1..4
- DEPTH, 8, FIFO entries; power of two, >= 2*RETIRE

Ports:
- clk  in  1  interface clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  RETIRE  per-slot retire valid
- in_order  in  RETIRE*64  per-slot order count
- in_insn  in  RETIRE*ILEN  per-slot instruction
- in_pc_rdata  in  RETIRE*XLEN  PC of instruction
- in_pc_wdata  in  RETIRE*XLEN  next PC
- in_trap  in  RETIRE  trapped flag
- in_halt  in  RETIRE  halted flag
- in_mode  in  RETIRE*2  privilege mode
- in_x_wb  in  RETIRE*32  GPR writeback mask (at most one bit set)
- in_x_wdata  in  RETIRE*XLEN  data for the written GPR
- in_ready  out  1  FIFO can absorb a full RETIRE group this cycle
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_order, out_insn, out_pc_rdata, out_pc_wdata, out_trap, out_halt, out_mode  out  64/ILEN/XLEN/XLEN/1/1/2  record fields
- out_rd  out  5  index of the written GPR
- out_rd_we  out  1  GPR write present
- out_rd_wdata  out  XLEN  GPR data
- err_order  out  1  sticky order-sequence error
- err_order_exp  out  64  expected order at the first error
- err_order_got  out  64  received order at the first error
- err_overflow  out  1  sticky dropped-record flag
- drop_count  out  16  records dropped; saturating

Behaviour:

Reset:
- All outputs 0.
- FIFO empty.
- Expected-order register invalid (seeded flag cleared).
- Reset asserted mid-operation discards all buffered records immediately (asynchronous).

Push path:
- in_ready = (DEPTH - count) >= RETIRE, computed from the registered count only.
- A pop in the same cycle does not raise in_ready.
- When in_ready is high, valid slots are compacted lowest-index first and written in one cycle.
- Sparse patterns are legal: e.g. valid=2'b10 writes one entry.
- When in_ready is low and any in_valid bit is set:
  - the whole group is dropped;
  - err_overflow is set;
  - drop_count += popcount(in_valid), saturating at 16'hFFFF.

Pop path:
- out_valid = count != 0.
- Outputs are driven from the FIFO head combinationally.
- Transfer occurs when out_valid && out_ready.
- Head data must hold stable while out_valid && !out_ready.

Occupancy:
- count_next = count + pushes - pop.
- Simultaneous push and pop are legal at any occupancy, including a push when count = DEPTH - RETIRE with a pop in the same cycle.

GPR decode:
- out_rd = index of the set bit in x_wb.
- out_rd_we = |x_wb.
- An x_wb bit for x0 yields out_rd_we = 0.
- Multiple set bits: lowest index wins. This is a pure function of x_wb; no error flag.

Order check, performed on each pop:
- States: UNSEEDED -> SEEDED.
- The first pop loads expected = order + 1 and moves to SEEDED.
- In SEEDED, order != expected:
  - sets err_order;
  - captures err_order_exp and err_order_got only on the first error;
  - sets expected = order + 1, so checking resynchronises.
- Expected wraps modulo 2^64.
- err_order, err_overflow and drop_count clear only on reset.

Latency:
- A record pushed in cycle N is visible on out_* in cycle N+1 at the earliest.

Optional Feature:
- Macro: RVVI_RETIRE_SERIALIZER_STATS_EN.
- When defined, adds three ports, all counting transfers (popped records):
  - stat_retired (out, 64): total records popped.
  - stat_traps (out, 32): popped records with trap=1.
  - stat_max_occ (out, $clog2(DEPTH)+1): high-water mark of count.
- All three counters reset to 0.
- stat_retired and stat_traps wrap; stat_max_occ is monotonic.
- When undefined, these ports and registers do not exist. Core behaviour is identical either way.

Decomposition:
- Package rvvi_trace_pkg holds:
  - RVVI_TRACE_VERSION_MAJOR/MINOR constants;
  - the order-check state enum (UNSEEDED, SEEDED);
  - localparam DROP_CNT_W = 16.
- The record struct depends on XLEN/ILEN, so it is declared inside the module.
- One sub-module: rvvi_retire_fifo.
  - Parameters: WIDTH, DEPTH, NWR.
  - Compacting multi-write, single-read FIFO with count output.
  - All compaction, pointer and wrap logic lives here.

Test Plan:
1. Reset, then in_valid=2'b11 with orders 0,1, out_ready=1 -> out_valid in the next cycle; orders 0 then 1 on consecutive cycles; err_order=0.
2. in_valid=2'b10 with order 5 after order 4 was popped -> single entry written, out_order=5, no error.
3. out_ready=0, groups of 2 until in_ready=0 at count=7 (DEPTH=8); then one more group of 2 -> err_overflow=1, drop_count=2, FIFO contents unchanged.
4. Pop orders 10, 11, 13, 14 -> err_order=1, err_order_exp=11... correction: err_order_exp=12, err_order_got=13; 14 produces no new capture.
5. Order 64'hFFFF_FFFF_FFFF_FFFF followed by 0 -> no error (wrap).
6. rst_n pulsed low with 4 entries buffered, asynchronously and mid-cycle -> out_valid=0 and all error flags cleared before the next clock; the next first pop re-seeds.
